eh2_lsu_dccm_stbuf: RTL and testbench



---
 rtl/eh2_lsu_dccm_stbuf.sv | 166 ++++++++++++++++
 tb/tb_eh2_lsu_dccm_stbuf.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eh2_lsu_dccm_stbuf.sv
// eh2_lsu_dccm_stbuf
//   Store buffer and DCCM port arbiter between the LSU commit logic and the
//   DCCM lo-bank ports. Committed full-word stores, which arrive with ECC
//   already appended, are queued in a circular FIFO. They drain to the DCCM
//   write port in cycles when no load owns the array. Buffered data forwards
//   to younger loads. Load-induced drain starvation is bounded by STARVE_MAX.
//
//   Optional feature macro: EH2_LSU_STBUF_COALESCE_EN
//     defined   : a store whose word address matches the youngest occupied
//                 entry overwrites that entry's data. If that entry is the
//                 last one and is draining this cycle, a new entry is
//                 allocated instead.
//     undefined : every accepted store allocates a new entry.
//
// Ports
//   clk, rst_l         core clock, asynchronous active-low reset
//   st_valid/st_ready  store handshake; st_addr (word aligned), st_data (+ECC)
//   ld_valid, ld_addr  load request for the DCCM this cycle
//   ld_stall           load lost arbitration to a drain; LSU retries
//   fwd_hit, fwd_data  youngest buffered store matching ld_addr word
//   dccm_rden/rd_addr  DCCM read port
//   dccm_wren/wr_addr/wr_data  DCCM lo-bank write port
//   sb_count, sb_empty occupancy
//
// All outputs are combinational from state and the current request inputs.
module eh2_lsu_dccm_stbuf #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 39,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic                     clk,
  input  logic                     rst_l,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [ADDR_W-1:0]        st_addr,
  input  logic [DATA_W-1:0]        st_data,
  input  logic                     ld_valid,
  input  logic [ADDR_W-1:0]        ld_addr,
  output logic                     ld_stall,
  output logic                     fwd_hit,
  output logic [DATA_W-1:0]        fwd_data,
  output logic                     dccm_rden,
  output logic [ADDR_W-1:0]        dccm_rd_addr_lo,
  output logic                     dccm_wren,
  output logic [ADDR_W-1:0]        dccm_wr_addr_lo,
  output logic [DATA_W-1:0]        dccm_wr_data_lo,
  output logic [$clog2(DEPTH):0]   sb_count,
  output logic                     sb_empty
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned WADDR_W = ADDR_W - 2;
  localparam int unsigned STV_W   = 8;

  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [STV_W-1:0]   starve_cnt;
  logic [WADDR_W-1:0] ent_addr [DEPTH];
  logic [DATA_W-1:0]  ent_data [DEPTH];

  logic               full;
  logic               not_empty;
  logic               push;
  logic               alloc;
  logic               coalesce;
  logic               force_drain;
  logic               drain;
  logic [WADDR_W-1:0] st_word;
  logic [PTR_W-1:0]   fwd_idx;

  // Store byte-offset bits carry no information for full-word stores.
  logic unused_st_lsb;
  assign unused_st_lsb = ^st_addr[1:0];

  assign st_word   = st_addr[ADDR_W-1:2];
  assign full      = (count == CNT_W'(DEPTH));
  assign not_empty = (count != '0);

  // Ready reflects only current occupancy, never a same-cycle pop.
  assign st_ready = !full;
  assign push     = st_valid && !full;

  // A store held off by a full buffer, or a starved drain, wins over the load.
  assign force_drain = (starve_cnt == STV_W'(STARVE_MAX)) || (full && st_valid);
  assign drain       = not_empty && (!ld_valid || force_drain);

`ifdef EH2_LSU_STBUF_COALESCE_EN
  logic [PTR_W-1:0] young_ptr;
  assign young_ptr = wr_ptr - PTR_W'(1);
  // The last entry leaving this cycle cannot absorb the store.
  assign coalesce  = push && not_empty
                     && (ent_addr[young_ptr] == st_word)
                     && !(drain && (count == CNT_W'(1)));
`else
  assign coalesce  = 1'b0;
`endif

  assign alloc = push && !coalesce;

  // Port arbitration
  assign dccm_wren       = drain;
  assign dccm_wr_addr_lo = drain ? {ent_addr[rd_ptr], 2'b00} : '0;
  assign dccm_wr_data_lo = drain ? ent_data[rd_ptr] : '0;
  assign dccm_rden       = ld_valid && !drain;
  assign ld_stall        = ld_valid && drain;
  assign dccm_rd_addr_lo = ld_addr;

  assign sb_count = count;
  assign sb_empty = !not_empty;

  // Forwarding: walk oldest to youngest so the last match wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      fwd_idx = rd_ptr + PTR_W'(k);
      if (ld_valid && (CNT_W'(k) < count)
          && (ent_addr[fwd_idx] == ld_addr[ADDR_W-1:2])) begin
        fwd_hit  = 1'b1;
        fwd_data = ent_data[fwd_idx];
      end
    end
  end

  // Pointers, occupancy and starvation counter
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
    end else begin
      if (alloc) wr_ptr <= wr_ptr + PTR_W'(1);
      if (drain) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(alloc) - CNT_W'(drain);
      if (drain || !not_empty) begin
        starve_cnt <= '0;
      end else if (ld_valid && (starve_cnt != STV_W'(STARVE_MAX))) begin
        starve_cnt <= starve_cnt + STV_W'(1);
      end
    end
  end

  // Entry storage
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_addr[i] <= '0;
        ent_data[i] <= '0;
      end
    end else if (alloc) begin
      ent_addr[wr_ptr] <= st_word;
      ent_data[wr_ptr] <= st_data;
    end
`ifdef EH2_LSU_STBUF_COALESCE_EN
    else if (coalesce) begin
      ent_data[young_ptr] <= st_data;
    end
`endif
  end

endmodule

// File: tb/tb_eh2_lsu_dccm_stbuf.sv
// Testbench for eh2_lsu_dccm_stbuf: directed vector table, hand-written
// corner sequences, then random traffic against a queue-based model.
module tb_eh2_lsu_dccm_stbuf;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 39;
  localparam int SM     = 8;

`ifdef EH2_LSU_STBUF_COALESCE_EN
  localparam bit COAL     = 1'b1;
  localparam int SEQ3_CNT = 1;
`else
  localparam bit COAL     = 1'b0;
  localparam int SEQ3_CNT = 2;
`endif

  logic              clk;
  logic              rst_l;
  logic              st_valid;
  logic              st_ready;
  logic [ADDR_W-1:0] st_addr;
  logic [DATA_W-1:0] st_data;
  logic              ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic              ld_stall;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic              dccm_rden;
  logic [ADDR_W-1:0] dccm_rd_addr_lo;
  logic              dccm_wren;
  logic [ADDR_W-1:0] dccm_wr_addr_lo;
  logic [DATA_W-1:0] dccm_wr_data_lo;
  logic [2:0]        sb_count;
  logic              sb_empty;

  eh2_lsu_dccm_stbuf #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(SM)
  ) dut (
    .clk(clk), .rst_l(rst_l),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_stall(ld_stall),
    .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .dccm_rden(dccm_rden), .dccm_rd_addr_lo(dccm_rd_addr_lo),
    .dccm_wren(dccm_wren), .dccm_wr_addr_lo(dccm_wr_addr_lo),
    .dccm_wr_data_lo(dccm_wr_data_lo),
    .sb_count(sb_count), .sb_empty(sb_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference model: ordered queue of pending stores, oldest at index 0.
  typedef struct {
    logic [13:0]       w;
    logic [DATA_W-1:0] d;
  } ment_t;
  ment_t mq[$];
  int    m_starve;

  // Drive one cycle at negedge, check against the model, then advance the model.
  task automatic cycle(input logic sv, input logic [15:0] sa, input logic [DATA_W-1:0] sd,
                       input logic lv, input logic [15:0] la);
    int n;
    bit frc, drn, hit, do_push;
    logic [DATA_W-1:0] fd;
    ment_t e;
    @(negedge clk);
    st_valid = sv; st_addr = sa; st_data = sd; ld_valid = lv; ld_addr = la;
    #2;
    n   = mq.size();
    frc = (m_starve == SM) || (n == DEPTH && sv);
    drn = (n != 0) && (!lv || frc);
    hit = 0; fd = '0;
    if (lv) for (int i = 0; i < n; i++) if (mq[i].w == la[15:2]) begin hit = 1; fd = mq[i].d; end
    chk("st_ready", st_ready, 64'(n != DEPTH));
    chk("sb_count", sb_count, 64'(n));
    chk("sb_empty", sb_empty, 64'(n == 0));
    chk("dccm_wren", dccm_wren, 64'(drn));
    chk("dccm_rden", dccm_rden, 64'(lv && !drn));
    chk("ld_stall", ld_stall, 64'(lv && drn));
    chk("rd_addr", dccm_rd_addr_lo, 64'(la));
    chk("fwd_hit", fwd_hit, 64'(hit));
    if (hit) chk("fwd_data", fwd_data, 64'(fd));
    if (drn) begin
      chk("wr_addr", dccm_wr_addr_lo, 64'({mq[0].w, 2'b00}));
      chk("wr_data", dccm_wr_data_lo, 64'(mq[0].d));
    end
    do_push = 0;
    if (sv && n != DEPTH) begin
      if (COAL && n != 0 && mq[n-1].w == sa[15:2] && !(drn && n == 1)) mq[n-1].d = sd;
      else do_push = 1;
    end
    if (drn) void'(mq.pop_front());
    if (do_push) begin e.w = sa[15:2]; e.d = sd; mq.push_back(e); end
    if (drn || n == 0) m_starve = 0;
    else if (lv && m_starve < SM) m_starve++;
  endtask

  task automatic idle_until_empty();
    for (int i = 0; i < DEPTH + 2; i++) cycle(0, 16'h0, '0, 0, 16'h0);
    chk("drained_empty", sb_empty, 64'(1));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_l = 0; st_valid = 0; st_addr = '0; st_data = '0; ld_valid = 0; ld_addr = '0;
    mq.delete(); m_starve = 0;
    repeat (2) @(negedge clk);
    #2;
    chk("rst_st_ready", st_ready, 64'(1));
    chk("rst_sb_empty", sb_empty, 64'(1));
    chk("rst_sb_count", sb_count, 64'(0));
    chk("rst_wren", dccm_wren, 64'(0));
    chk("rst_rden", dccm_rden, 64'(0));
    chk("rst_stall", ld_stall, 64'(0));
    chk("rst_fwd_hit", fwd_hit, 64'(0));
    chk("rst_fwd_data", fwd_data, 64'(0));
    chk("rst_wr_addr", dccm_wr_addr_lo, 64'(0));
    chk("rst_wr_data", dccm_wr_data_lo, 64'(0));
    chk("rst_rd_addr", dccm_rd_addr_lo, 64'(0));
    rst_l = 1;
  endtask

  // Directed vectors with hand-derived expectations.
  typedef struct {
    logic              sv;
    logic [15:0]       sa;
    logic [DATA_W-1:0] sd;
    logic              lv;
    logic [15:0]       la;
    logic              e_wren;
    logic [15:0]       e_waddr;
    logic              e_rden;
    logic              e_stall;
    int                e_cnt;
    logic              e_hit;
    logic [DATA_W-1:0] e_fd;
  } vec_t;
  vec_t tv[$];

  task automatic add(input logic sv, input logic [15:0] sa, input logic [DATA_W-1:0] sd,
                     input logic lv, input logic [15:0] la, input logic e_wren,
                     input logic [15:0] e_waddr, input logic e_rden, input logic e_stall,
                     input int e_cnt, input logic e_hit, input logic [DATA_W-1:0] e_fd);
    vec_t v;
    v.sv = sv; v.sa = sa; v.sd = sd; v.lv = lv; v.la = la;
    v.e_wren = e_wren; v.e_waddr = e_waddr; v.e_rden = e_rden; v.e_stall = e_stall;
    v.e_cnt = e_cnt; v.e_hit = e_hit; v.e_fd = e_fd;
    tv.push_back(v);
  endtask

  localparam logic [DATA_W-1:0] D1 = 39'h7A_1234_5678;
  localparam logic [DATA_W-1:0] D2 = 39'h05_CAFE_BEEF;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic              rsv, rlv;
    logic [15:0]       rsa, rla;
    logic [DATA_W-1:0] rsd;

    rst_l = 0; st_valid = 0; st_addr = '0; st_data = '0; ld_valid = 0; ld_addr = '0;
    mq.delete(); m_starve = 0;

    // Three back-to-back stores, no loads: writes appear one cycle later, in order.
    add(1, 16'h100, 39'h11, 0, 16'h0, 0, 16'h0,   0, 0, 0, 0, '0);
    add(1, 16'h104, 39'h22, 0, 16'h0, 1, 16'h100, 0, 0, 1, 0, '0);
    add(1, 16'h108, 39'h33, 0, 16'h0, 1, 16'h104, 0, 0, 1, 0, '0);
    add(0, 16'h0,   '0,     0, 16'h0, 1, 16'h108, 0, 0, 1, 0, '0);
    add(0, 16'h0,   '0,     0, 16'h0, 0, 16'h0,   0, 0, 0, 0, '0);
    // Continuous loads starve the drain until the counter reaches STARVE_MAX.
    add(1, 16'h100, 39'h44, 1, 16'h300, 0, 16'h0, 1, 0, 0, 0, '0);
    add(1, 16'h104, 39'h55, 1, 16'h300, 0, 16'h0, 1, 0, 1, 0, '0);
    for (int i = 0; i < 7; i++) add(0, 16'h0, '0, 1, 16'h300, 0, 16'h0, 1, 0, 2, 0, '0);
    add(0, 16'h0, '0, 1, 16'h300, 1, 16'h100, 0, 1, 2, 0, '0);
    add(0, 16'h0, '0, 1, 16'h300, 0, 16'h0,   1, 0, 1, 0, '0);
    add(0, 16'h0, '0, 0, 16'h0,   1, 16'h104, 0, 0, 1, 0, '0);
    add(0, 16'h0, '0, 0, 16'h0,   0, 16'h0,   0, 0, 0, 0, '0);
    // Two stores to the same word, then a load forwards the younger data.
    add(1, 16'h200, D1, 1, 16'h500, 0, 16'h0, 1, 0, 0, 0, '0);
    add(1, 16'h200, D2, 1, 16'h500, 0, 16'h0, 1, 0, 1, 0, '0);
    add(0, 16'h0,   '0, 1, 16'h202, 0, 16'h0, 1, 0, SEQ3_CNT, 1, D2);

    do_reset();

    for (int i = 0; i < tv.size(); i++) begin
      cycle(tv[i].sv, tv[i].sa, tv[i].sd, tv[i].lv, tv[i].la);
      chk($sformatf("tv%0d_wren", i), dccm_wren, 64'(tv[i].e_wren));
      if (tv[i].e_wren) chk($sformatf("tv%0d_waddr", i), dccm_wr_addr_lo, 64'(tv[i].e_waddr));
      chk($sformatf("tv%0d_rden", i), dccm_rden, 64'(tv[i].e_rden));
      chk($sformatf("tv%0d_stall", i), ld_stall, 64'(tv[i].e_stall));
      chk($sformatf("tv%0d_cnt", i), sb_count, 64'(tv[i].e_cnt));
      chk($sformatf("tv%0d_hit", i), fwd_hit, 64'(tv[i].e_hit));
      if (tv[i].e_hit) chk($sformatf("tv%0d_fd", i), fwd_data, 64'(tv[i].e_fd));
    end
    idle_until_empty();

    // Fill under loads, then a store against a full buffer forces a drain.
    cycle(1, 16'h010, 39'h1, 1, 16'h300);
    cycle(1, 16'h014, 39'h2, 1, 16'h300);
    cycle(1, 16'h018, 39'h3, 1, 16'h300);
    cycle(1, 16'h01C, 39'h4, 1, 16'h300);
    cycle(1, 16'h020, 39'h5, 1, 16'h300);
    chk("full_ready", st_ready, 64'(0));
    chk("full_force_wren", dccm_wren, 64'(1));
    chk("full_force_addr", dccm_wr_addr_lo, 64'(16'h010));
    chk("full_force_stall", ld_stall, 64'(1));
    cycle(1, 16'h020, 39'h5, 1, 16'h300);
    chk("after_force_ready", st_ready, 64'(1));
    chk("after_force_rden", dccm_rden, 64'(1));
    cycle(0, 16'h0, '0, 1, 16'h020);
    chk("wrap_fwd_hit", fwd_hit, 64'(1));
    chk("wrap_fwd_data", fwd_data, 64'(39'h5));
    chk("wrap_count", sb_count, 64'(4));
    cycle(0, 16'h0, '0, 0, 16'h0); chk("wrap_drain0", dccm_wr_addr_lo, 64'(16'h014));
    cycle(0, 16'h0, '0, 0, 16'h0); chk("wrap_drain1", dccm_wr_addr_lo, 64'(16'h018));
    cycle(0, 16'h0, '0, 0, 16'h0); chk("wrap_drain2", dccm_wr_addr_lo, 64'(16'h01C));
    cycle(0, 16'h0, '0, 0, 16'h0); chk("wrap_drain3", dccm_wr_addr_lo, 64'(16'h020));
    idle_until_empty();

    // Same-word store while the only entry drains: a second write must follow.
    cycle(1, 16'h400, 39'hA, 1, 16'h300);
    cycle(1, 16'h400, 39'hB, 0, 16'h0);
    chk("coal_drain_wren", dccm_wren, 64'(1));
    chk("coal_drain_data", dccm_wr_data_lo, 64'(39'hA));
    cycle(0, 16'h0, '0, 0, 16'h0);
    chk("coal_second_wren", dccm_wren, 64'(1));
    chk("coal_second_data", dccm_wr_data_lo, 64'(39'hB));
    chk("coal_second_cnt", sb_count, 64'(1));
    idle_until_empty();

    // Asynchronous reset with three entries pending.
    cycle(1, 16'h600, 39'h61, 1, 16'h300);
    cycle(1, 16'h604, 39'h62, 1, 16'h300);
    cycle(1, 16'h608, 39'h63, 1, 16'h300);
    @(negedge clk);
    st_valid = 0; ld_valid = 0; ld_addr = '0;
    #2;
    chk("pre_rst_wren", dccm_wren, 64'(1));
    rst_l = 0;
    #1;
    chk("mid_rst_wren", dccm_wren, 64'(0));
    chk("mid_rst_count", sb_count, 64'(0));
    chk("mid_rst_empty", sb_empty, 64'(1));
    mq.delete(); m_starve = 0;
    #1 rst_l = 1;
    cycle(0, 16'h0, '0, 1, 16'h600);
    chk("post_rst_no_fwd", fwd_hit, 64'(0));
    cycle(0, 16'h0, '0, 0, 16'h0);
    chk("post_rst_no_wr", dccm_wren, 64'(0));

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rsv = ($urandom_range(0, 99) < 60);
      rlv = ($urandom_range(0, 99) < 70);
      rsa = 16'(16'h40 + $urandom_range(0, 7) * 4 + $urandom_range(0, 3));
      rla = 16'(16'h40 + $urandom_range(0, 9) * 4 + $urandom_range(0, 3));
      rsd = DATA_W'({$urandom, $urandom});
      cycle(rsv, rsa, rsd, rlv, rla);
    end
    idle_until_empty();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
